// File: rtl/note_scheduler_if.sv
// Handshake and gate signals between the note scheduler and the shared tone generator.
interface note_scheduler_if;
    logic        tg_load;
    logic        tg_ready;
    logic [17:0] tg_half_period;
    logic        tg_enable;

    modport master (
        output tg_load,
        output tg_half_period,
        output tg_enable,
        input  tg_ready
    );

    modport slave (
        input  tg_load,
        input  tg_half_period,
        input  tg_enable,
        output tg_ready
    );
endinterface

// File: rtl/note_scheduler.sv
// Serves held keys one at a time on the shared tone generator: lowest key wins,
// each note is gated for at least MIN_NOTE_CYC cycles and followed by a silent gap.
module note_scheduler #(
    parameter int unsigned MIN_NOTE_CYC = 5_000_000,
    parameter int unsigned GAP_CYC      = 500_000,
    parameter int unsigned CNT_W        = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       key_level,
    note_scheduler_if.master  tg,
    output logic [3:0]        note_idx,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_NOTE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_q, load_d;
    logic             en_q, en_d;
    logic [17:0]      hp_q, hp_d;
    logic [3:0]       idx_q, idx_d;
    logic             busy_q, busy_d;
    logic [3:0]       first_idx;

    // Chromatic half-periods C4..D#5 at 50 MHz.
    function automatic logic [17:0] half_period(input logic [3:0] i);
        case (i)
            4'd0:    half_period = 18'd95556;
            4'd1:    half_period = 18'd90193;
            4'd2:    half_period = 18'd85131;
            4'd3:    half_period = 18'd80353;
            4'd4:    half_period = 18'd75843;
            4'd5:    half_period = 18'd71586;
            4'd6:    half_period = 18'd67569;
            4'd7:    half_period = 18'd63776;
            4'd8:    half_period = 18'd60197;
            4'd9:    half_period = 18'd56818;
            4'd10:   half_period = 18'd53629;
            4'd11:   half_period = 18'd50619;
            4'd12:   half_period = 18'd47778;
            4'd13:   half_period = 18'd45097;
            4'd14:   half_period = 18'd42566;
            default: half_period = 18'd40177;
        endcase
    endfunction

    // Descending scan so the last hit is the lowest set bit.
    always_comb begin
        first_idx = '0;
        for (int unsigned i = 16; i > 0; i--) begin
            if (key_level[i-1]) first_idx = 4'(i - 1);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        en_d    = en_q;
        hp_d    = hp_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (key_level != '0) begin
                    idx_d   = first_idx;
                    hp_d    = half_period(first_idx);
                    load_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (tg.tg_ready) begin
                    load_d  = 1'b0;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (cnt_q == MIN_LAST) begin
                    if (!key_level[idx_q]) begin
                        en_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            en_q    <= 1'b0;
            hp_q    <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            en_q    <= en_d;
            hp_q    <= hp_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    assign tg.tg_load        = load_q;
    assign tg.tg_enable      = en_q;
    assign tg.tg_half_period = hp_q;
    assign note_idx          = idx_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed self-checking bench for note_scheduler with MIN_NOTE_CYC=20, GAP_CYC=4.
module tb_note_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] key_level;
    logic [3:0]  note_idx;
    logic        busy;
    int          passed = 0;
    int          total  = 0;
    int          cnt;

    note_scheduler_if tgi ();

    note_scheduler #(
        .MIN_NOTE_CYC(20),
        .GAP_CYC     (4),
        .CNT_W       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_level (key_level),
        .tg        (tgi.master),
        .note_idx  (note_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Counts negedge samples while tg_enable stays high; optionally changes keys mid-note.
    task automatic count_enable(input int change_at, input logic [15:0] new_keys, output int n);
        n = 0;
        while (tgi.tg_enable === 1'b1 && n < 200) begin
            n++;
            if (n == change_at) key_level = new_keys;
            step(1);
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            step(1);
        end
    endtask

    task automatic count_until_load(output int n);
        n = 0;
        while (tgi.tg_load !== 1'b1 && n < 50) begin
            n++;
            step(1);
        end
    endtask

    initial begin
        rst          = 1'b1;
        key_level    = '0;
        tgi.tg_ready = 1'b1;
        step(3);
        chk("rst_load",   32'(tgi.tg_load), 0);
        chk("rst_enable", 32'(tgi.tg_enable), 0);
        chk("rst_hp",     32'(tgi.tg_half_period), 0);
        chk("rst_idx",    32'(note_idx), 0);
        chk("rst_busy",   32'(busy), 0);
        rst = 1'b0;
        step(1);

        // Single tap on key 9
        key_level = 16'h0200;
        step(1);
        chk("tap_load",   32'(tgi.tg_load), 1);
        chk("tap_hp",     32'(tgi.tg_half_period), 56818);
        chk("tap_idx",    32'(note_idx), 9);
        chk("tap_busy",   32'(busy), 1);
        chk("tap_en_pre", 32'(tgi.tg_enable), 0);
        step(1);
        chk("tap_load_1cyc", 32'(tgi.tg_load), 0);
        chk("tap_en_on",     32'(tgi.tg_enable), 1);
        key_level = '0;
        count_enable(0, '0, cnt);
        chk("tap_en_len", 32'(cnt), 20);
        count_busy(cnt);
        chk("tap_gap_len", 32'(cnt), 4);
        chk("tap_busy_end", 32'(busy), 0);
        chk("tap_en_end",   32'(tgi.tg_enable), 0);

        // Priority: keys 4, 12, 15 together; then only 15 held
        key_level = 16'h9010;
        step(1);
        chk("prio_idx", 32'(note_idx), 4);
        chk("prio_hp",  32'(tgi.tg_half_period), 75843);
        key_level = 16'h8000;
        step(1);
        count_enable(0, 16'h8000, cnt);
        chk("prio_en_len", 32'(cnt), 20);
        count_until_load(cnt);
        chk("prio_wait", 32'(cnt), 5);
        chk("prio2_idx", 32'(note_idx), 15);
        chk("prio2_hp",  32'(tgi.tg_half_period), 40177);
        key_level = '0;
        step(1);
        count_enable(0, '0, cnt);
        chk("prio2_en_len", 32'(cnt), 20);
        count_busy(cnt);
        chk("prio2_gap", 32'(cnt), 4);

        // Backpressure then long hold on key 0
        tgi.tg_ready = 1'b0;
        key_level    = 16'h0001;
        step(1);
        for (int i = 0; i < 7; i++) begin
            chk("bp_load", 32'(tgi.tg_load), 1);
            chk("bp_hp",   32'(tgi.tg_half_period), 95556);
            chk("bp_idx",  32'(note_idx), 0);
            chk("bp_en",   32'(tgi.tg_enable), 0);
            step(1);
        end
        tgi.tg_ready = 1'b1;
        step(1);
        chk("bp_en_on",   32'(tgi.tg_enable), 1);
        chk("bp_load_off", 32'(tgi.tg_load), 0);
        count_enable(50, '0, cnt);
        chk("hold_en_len", 32'(cnt), 50);
        chk("hold_hp", 32'(tgi.tg_half_period), 95556);
        count_busy(cnt);
        chk("hold_gap", 32'(cnt), 4);

        // Release during LOAD, key 12 pressed mid-PLAY
        tgi.tg_ready = 1'b0;
        key_level    = 16'h0004;
        step(1);
        chk("rel_idx", 32'(note_idx), 2);
        key_level = '0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("rel_load_held", 32'(tgi.tg_load), 1);
        end
        tgi.tg_ready = 1'b1;
        step(1);
        count_enable(5, 16'h1000, cnt);
        chk("rel_en_len",  32'(cnt), 20);
        chk("rel_idx_kept", 32'(note_idx), 2);
        count_until_load(cnt);
        chk("late_wait", 32'(cnt), 5);
        chk("late_idx",  32'(note_idx), 12);
        chk("late_hp",   32'(tgi.tg_half_period), 47778);
        key_level = '0;
        step(1);
        count_enable(0, '0, cnt);
        chk("late_en_len", 32'(cnt), 20);
        count_busy(cnt);
        chk("late_gap", 32'(cnt), 4);

        // Reset mid-PLAY
        key_level = 16'h0001;
        step(2);
        chk("mid_en_on", 32'(tgi.tg_enable), 1);
        step(3);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("mrst_enable", 32'(tgi.tg_enable), 0);
            chk("mrst_busy",   32'(busy), 0);
            chk("mrst_load",   32'(tgi.tg_load), 0);
            chk("mrst_hp",     32'(tgi.tg_half_period), 0);
            chk("mrst_idx",    32'(note_idx), 0);
        end
        rst       = 1'b0;
        key_level = '0;
        step(1);
        chk("post_busy",   32'(busy), 0);
        chk("post_enable", 32'(tgi.tg_enable), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
